rptr_fwft_reader: RTL and testbench

RPTR_FWFT_READER -- requirements
Module: rptr_fwft_reader

---
 rtl/rptr_fwft_reader.sv | 87 ++++++++
 tb/tb_rptr_fwft_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rptr_fwft_reader.sv
// Read side of an async FIFO: synchronizes the Gray write pointer, pops memory into a
// first-word-fall-through output register, and tracks fill level and pointer sanity.
module rptr_fwft_reader #(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8,
  parameter int AE_LEVEL = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rwptr,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                dready,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DATASIZE-1:0] dout,
  output logic                dvalid,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty,
  output logic                rptr_err
);

  localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [ADDRSIZE:0] AE    = AE_LEVEL[ADDRSIZE:0];

  logic [ADDRSIZE:0] rwptr1, rwptr2;
  logic [ADDRSIZE:0] rwbin;
  logic [ADDRSIZE:0] rbin, rbnext, rgnext;
  logic [ADDRSIZE:0] diff;
  logic              rinc;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    rwbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rwbin[i] = ^(rwptr2 >> i);
    end
  end

  assign rinc   = !rempty && (!dvalid || dready);
  assign rbnext = rbin + {{ADDRSIZE{1'b0}}, rinc};
  assign rgnext = (rbnext >> 1) ^ rbnext;
  assign diff   = rwbin - rbnext;
  assign raddr  = rbin[ADDRSIZE-1:0];

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rwptr1 <= '0;
      rwptr2 <= '0;
    end else begin
      rwptr1 <= rwptr;
      rwptr2 <= rwptr1;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
      rptr_err      <= 1'b0;
    end else begin
      rbin          <= rbnext;
      rptr          <= rgnext;
      rempty        <= (rgnext == rwptr2);
      rlevel        <= diff;
      ralmost_empty <= (diff <= AE);
      if (diff > DEPTH) rptr_err <= 1'b1;
    end
  end

  // Output register only changes on a pop or when its word is consumed
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      dout   <= '0;
      dvalid <= 1'b0;
    end else if (rinc) begin
      dout   <= rdata;
      dvalid <= 1'b1;
    end else if (dready) begin
      dvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rptr_fwft_reader.sv
// Directed bench for rptr_fwft_reader: a small memory model feeds rdata and a
// write pointer model drives rwptr; outputs are sampled on the falling edge.
module tb_rptr_fwft_reader;

  logic       rclk = 1'b0;
  logic       rrst = 1'b0;
  logic [4:0] rwptr = '0;
  logic [7:0] rdata;
  logic       dready = 1'b0;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [7:0] dout;
  logic       dvalid;
  logic [4:0] rlevel;
  logic       ralmost_empty;
  logic       rptr_err;

  logic [7:0] mem [16];
  logic [4:0] wbin;
  int errors = 0;
  int checks = 0;

  rptr_fwft_reader #(.ADDRSIZE(4), .DATASIZE(8), .AE_LEVEL(2)) dut (
    .rclk(rclk), .rrst(rrst), .rwptr(rwptr), .rdata(rdata), .dready(dready),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .dout(dout), .dvalid(dvalid),
    .rlevel(rlevel), .ralmost_empty(ralmost_empty), .rptr_err(rptr_err)
  );

  always #5 rclk = ~rclk;
  assign rdata = mem[raddr];

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    rrst = 1'b1; dready = 1'b0; wbin = '0; rwptr = '0;
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic wr(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wbin[3:0]] = base + 8'(i);
      wbin = wbin + 5'd1;
    end
    rwptr = gray(wbin);
  endtask

  task automatic test_reset();
    wbin = '0; rwptr = '0; dready = 1'b1;
    #1 rrst = 1'b1;
    @(negedge rclk);
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty: got %b want 1", rempty); end
    checks++; if (dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b want 0", dvalid); end
    checks++; if (rptr !== 5'd0) begin errors++; $display("FAIL reset_rptr: got %b want 00000", rptr); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if (rlevel !== 5'd0 || raddr !== 4'd0) begin errors++; $display("FAIL reset_level_addr: got %0d/%0d want 0/0", rlevel, raddr); end
    checks++; if (ralmost_empty !== 1'b1 || rptr_err !== 1'b0) begin errors++; $display("FAIL reset_ae_err: got %b%b want 10", ralmost_empty, rptr_err); end
    @(negedge rclk);
    rrst = 1'b0; dready = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    wr(1, 8'hA5);
    repeat (2) @(negedge rclk);
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL lat_edge2_rempty: got %b want 1", rempty); end
    @(negedge rclk);
    checks++; if (rempty !== 1'b0 || dvalid !== 1'b0) begin errors++; $display("FAIL lat_edge3: rempty/dvalid got %b/%b want 0/0", rempty, dvalid); end
    @(negedge rclk);
    checks++; if (dvalid !== 1'b1 || dout !== 8'hA5) begin errors++; $display("FAIL lat_edge4: dvalid/dout got %b/%h want 1/a5", dvalid, dout); end
    repeat (3) @(negedge rclk);
    checks++; if (dvalid !== 1'b1 || dout !== 8'hA5) begin errors++; $display("FAIL lat_hold: dvalid/dout got %b/%h want 1/a5", dvalid, dout); end
    checks++; if (rlevel !== 5'd0 || ralmost_empty !== 1'b1 || rempty !== 1'b1) begin errors++; $display("FAIL lat_level: lvl/ae/empty got %0d/%b/%b want 0/1/1", rlevel, ralmost_empty, rempty); end
    checks++; if (rptr !== 5'b00001) begin errors++; $display("FAIL lat_rptr: got %b want 00001", rptr); end
  endtask

  task automatic test_async_reset();
    #2 rrst = 1'b1;
    #1;
    checks++; if (dvalid !== 1'b0 || rempty !== 1'b1 || rptr !== 5'd0 || dout !== 8'h00) begin
      errors++; $display("FAIL async_reset: dvalid/rempty/rptr/dout got %b/%b/%b/%h want 0/1/00000/00", dvalid, rempty, rptr, dout);
    end
    wbin = '0; rwptr = '0;
    @(negedge rclk);
    rrst = 1'b0;
    wr(1, 8'h3C);
    repeat (3) @(negedge rclk);
    checks++; if (dvalid !== 1'b0 || rempty !== 1'b0) begin errors++; $display("FAIL post_reset_edge3: dvalid/rempty got %b/%b want 0/0", dvalid, rempty); end
    @(negedge rclk);
    checks++; if (dvalid !== 1'b1 || dout !== 8'h3C) begin errors++; $display("FAIL post_reset_word: dvalid/dout got %b/%h want 1/3c", dvalid, dout); end
  endtask

  task automatic test_levels();
    do_reset();
    wr(3, 8'h10);
    repeat (3) @(negedge rclk);
    checks++; if (rlevel !== 5'd3 || ralmost_empty !== 1'b0) begin errors++; $display("FAIL level3: lvl/ae got %0d/%b want 3/0", rlevel, ralmost_empty); end
    @(negedge rclk);
    checks++; if (rlevel !== 5'd2 || ralmost_empty !== 1'b1) begin errors++; $display("FAIL level2: lvl/ae got %0d/%b want 2/1", rlevel, ralmost_empty); end
    checks++; if (dvalid !== 1'b1 || dout !== 8'h10) begin errors++; $display("FAIL level_word: dvalid/dout got %b/%h want 1/10", dvalid, dout); end
  endtask

  task automatic test_back_to_back();
    int k;
    do_reset();
    dready = 1'b1;
    wr(16, 8'h20);
    repeat (3) @(negedge rclk);
    checks++; if (rlevel !== 5'd16 || rptr_err !== 1'b0 || rempty !== 1'b0) begin errors++; $display("FAIL full_level: lvl/err/empty got %0d/%b/%b want 16/0/0", rlevel, rptr_err, rempty); end
    k = 0;
    while (!dvalid && k < 5) begin @(negedge rclk); k++; end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dvalid !== 1'b1 || dout !== 8'h20 + 8'(i)) begin errors++; $display("FAIL b2b_word%0d: dvalid/dout got %b/%h want 1/%h", i, dvalid, dout, 8'h20 + 8'(i)); end
      @(negedge rclk);
    end
    checks++; if (dvalid !== 1'b0 || rempty !== 1'b1) begin errors++; $display("FAIL b2b_end: dvalid/rempty got %b/%b want 0/1", dvalid, rempty); end
    checks++; if (rptr !== 5'b11000 || rlevel !== 5'd0) begin errors++; $display("FAIL b2b_rptr: rptr/lvl got %b/%0d want 11000/0", rptr, rlevel); end
  endtask

  task automatic test_wrap();
    int written, got, cyc, n;
    do_reset();
    written = 0; got = 0; cyc = 0;
    while (got < 40 && cyc < 2000) begin
      @(negedge rclk);
      cyc++;
      dready = (cyc % 3 != 0);
      if (dvalid && dready) begin
        checks++; if (dout !== 8'h40 + 8'(got)) begin errors++; $display("FAIL wrap_word%0d: got %h want %h", got, dout, 8'h40 + 8'(got)); end
        got++;
      end
      if (written < 40 && written - got <= 9) begin
        n = (40 - written < 7) ? 40 - written : 7;
        wr(n, 8'h40 + 8'(written));
        written += n;
      end
    end
    checks++; if (got != 40) begin errors++; $display("FAIL wrap_count: got %0d words want 40", got); end
    dready = 1'b1;
    repeat (3) @(negedge rclk);
    checks++; if (rempty !== 1'b1 || dvalid !== 1'b0 || rlevel !== 5'd0) begin errors++; $display("FAIL wrap_end: empty/dvalid/lvl got %b/%b/%0d want 1/0/0", rempty, dvalid, rlevel); end
    checks++; if (rptr !== 5'b01100 || rptr_err !== 1'b0) begin errors++; $display("FAIL wrap_rptr: rptr/err got %b/%b want 01100/0", rptr, rptr_err); end
  endtask

  task automatic test_ptr_err();
    do_reset();
    wbin = 5'd20;
    rwptr = gray(wbin);
    repeat (2) @(negedge rclk);
    checks++; if (rptr_err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", rptr_err); end
    @(negedge rclk);
    checks++; if (rptr_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", rptr_err); end
    repeat (10) @(negedge rclk);
    checks++; if (rptr_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", rptr_err); end
    do_reset();
    @(negedge rclk);
    checks++; if (rptr_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", rptr_err); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_latency();
    test_async_reset();
    test_levels();
    test_back_to_back();
    test_wrap();
    test_ptr_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
